// File: rtl/sum_result_fifo_pkg.sv
// Shared definitions for the adding machine: ALU op codes used upstream,
// plus the default geometry of the sum result FIFO and its drop counter.
package sum_result_fifo_pkg;

    // ALU op codes of the adding machine (used by the upstream stages).
    typedef enum logic [1:0] {
        ALU_ADD  = 2'd0,
        ALU_SUB  = 2'd1,
        ALU_PASS = 2'd2,
        ALU_CLR  = 2'd3
    } alu_op_e;

    // Default FIFO geometry.
    localparam int FIFO_WIDTH  = 32;
    localparam int FIFO_DEPTH  = 4;
    localparam int FIFO_ADDR_W = 2;
    localparam int FIFO_DROP_W = 16;

    // Saturation value of the default-width drop counter.
    localparam logic [FIFO_DROP_W-1:0] DROP_SAT = {FIFO_DROP_W{1'b1}};

endpackage

// File: rtl/sum_result_fifo_if.sv
// Stream bus of the sum result FIFO: capture side from the adder, valid/ready
// output side to the consumer, and occupancy/drop status.
interface sum_result_fifo_if
    import sum_result_fifo_pkg::*;
#(
    parameter int WIDTH  = FIFO_WIDTH,
    parameter int ADDR_W = FIFO_ADDR_W,
    parameter int DROP_W = FIFO_DROP_W
) ();

    logic [WIDTH-1:0]  in_data;
    logic              in_valid;
    logic [WIDTH-1:0]  out_data;
    logic              out_valid;
    logic              out_ready;
    logic              full;
    logic              empty;
    logic [ADDR_W:0]   count;
    logic [DROP_W-1:0] drop_count;

    // Environment side: adder output plus consumer ready.
    modport master (
        output in_data, in_valid, out_ready,
        input  out_data, out_valid, full, empty, count, drop_count
    );

    // FIFO side.
    modport slave (
        input  in_data, in_valid, out_ready,
        output out_data, out_valid, full, empty, count, drop_count
    );

endinterface

// File: rtl/sum_fifo_storage.sv
// DEPTH x WIDTH register file for the sum FIFO: one synchronous write port,
// one asynchronous read port, asynchronous active-low clear of every entry.
module sum_fifo_storage
    import sum_result_fifo_pkg::*;
#(
    parameter int WIDTH  = FIFO_WIDTH,
    parameter int DEPTH  = FIFO_DEPTH,
    parameter int ADDR_W = FIFO_ADDR_W
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              wr_en,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [WIDTH-1:0]  wr_data,
    input  logic [ADDR_W-1:0] rd_addr,
    output logic [WIDTH-1:0]  rd_data
);

    logic [WIDTH-1:0] mem_q [DEPTH];

    // Entry storage: cleared on reset, written on wr_en.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int unsigned i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else if (wr_en) begin
            mem_q[wr_addr] <= wr_data;
        end
    end

    assign rd_data = mem_q[rd_addr];

endmodule

// File: rtl/sum_result_fifo.sv
// Downstream stage of the adding machine: buffers running sums in a small
// FIFO and streams them out on valid/ready. Samples arriving while full are
// dropped (never stalling the adder) and counted in a saturating counter.
module sum_result_fifo
    import sum_result_fifo_pkg::*;
#(
    parameter int WIDTH  = FIFO_WIDTH,
    parameter int DEPTH  = FIFO_DEPTH,
    parameter int ADDR_W = FIFO_ADDR_W,
    parameter int DROP_W = FIFO_DROP_W
) (
    input  logic             clk,
    input  logic             reset,
    sum_result_fifo_if.slave bus
);

    localparam logic [ADDR_W:0]   CNT_FULL = (ADDR_W + 1)'(DEPTH);
    localparam logic [ADDR_W:0]   CNT_ONE  = (ADDR_W + 1)'(1);
    localparam logic [ADDR_W-1:0] PTR_ONE  = ADDR_W'(1);
    localparam logic [DROP_W-1:0] DROP_ONE = DROP_W'(1);
    localparam logic [DROP_W-1:0] DROP_MAX = '1;

    logic [ADDR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [ADDR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [ADDR_W:0]   count_q, count_d;
    logic [DROP_W-1:0] drop_q, drop_d;

    logic full, empty, push, pop, drop;

    // Status is decoded from the registered count only, so nothing on the
    // input side reaches the outputs combinationally.
    assign full  = (count_q == CNT_FULL);
    assign empty = (count_q == '0);
    assign pop   = !empty && bus.out_ready;
    assign push  = bus.in_valid && (!full || pop);
    assign drop  = bus.in_valid && full && !pop;

    sum_fifo_storage #(
        .WIDTH  (WIDTH),
        .DEPTH  (DEPTH),
        .ADDR_W (ADDR_W)
    ) u_storage (
        .clk     (clk),
        .reset   (reset),
        .wr_en   (push),
        .wr_addr (wr_ptr_q),
        .wr_data (bus.in_data),
        .rd_addr (rd_ptr_q),
        .rd_data (bus.out_data)
    );

    // Next-state for pointers, occupancy and the saturating drop counter.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        drop_d   = drop_q;
        if (push) wr_ptr_d = wr_ptr_q + PTR_ONE;
        if (pop)  rd_ptr_d = rd_ptr_q + PTR_ONE;
        if (push && !pop)      count_d = count_q + CNT_ONE;
        else if (pop && !push) count_d = count_q - CNT_ONE;
        if (drop && (drop_q != DROP_MAX)) drop_d = drop_q + DROP_ONE;
    end

    // Control registers with asynchronous clear.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            drop_q   <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            drop_q   <= drop_d;
        end
    end

    assign bus.out_valid  = !empty;
    assign bus.full       = full;
    assign bus.empty      = empty;
    assign bus.count      = count_q;
    assign bus.drop_count = drop_q;

endmodule

// File: tb/tb_sum_result_fifo.sv
// Directed bench for sum_result_fifo: a table of per-cycle stimulus with
// hand-computed post-edge state, plus sequences for wrap-around and
// asynchronous reset in the middle of a stream.
module tb_sum_result_fifo;

    typedef struct {
        logic        vi;
        logic [31:0] d;
        logic        rdy;
        logic [2:0]  cnt;
        logic        ov;
        logic [31:0] od;
        logic        full;
        logic [15:0] drop;
    } vec_t;

    logic clk;
    logic reset;
    int   n_tests;
    int   n_fail;
    vec_t vecs[$];

    sum_result_fifo_if #(.WIDTH(32), .ADDR_W(2), .DROP_W(16)) bus ();

    sum_result_fifo #(
        .WIDTH  (32),
        .DEPTH  (4),
        .ADDR_W (2),
        .DROP_W (16)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    function automatic vec_t mk(logic vi, logic [31:0] d, logic rdy, logic [2:0] cnt,
                                logic ov, logic [31:0] od, logic full, logic [15:0] drop);
        vec_t v;
        v.vi = vi; v.d = d; v.rdy = rdy; v.cnt = cnt;
        v.ov = ov; v.od = od; v.full = full; v.drop = drop;
        return v;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h)", name, act, act, exp, exp);
        end
    endtask

    task automatic chk_state(input string tag, input logic [2:0] cnt, input logic ov,
                             input logic [31:0] od, input logic full, input logic [15:0] drop);
        chk({tag, ".count"}, 32'(bus.count), 32'(cnt));
        chk({tag, ".out_valid"}, 32'(bus.out_valid), 32'(ov));
        chk({tag, ".empty"}, 32'(bus.empty), 32'(cnt == 3'd0));
        chk({tag, ".full"}, 32'(bus.full), 32'(full));
        chk({tag, ".drop_count"}, 32'(bus.drop_count), 32'(drop));
        if (ov) chk({tag, ".out_data"}, bus.out_data, od);
    endtask

    // Drive inputs between edges, clock once, sample 1 ns after the edge.
    task automatic step(input logic vi, input logic [31:0] d, input logic rdy);
        bus.in_valid  = vi;
        bus.in_data   = d;
        bus.out_ready = rdy;
        @(posedge clk);
        #1;
    endtask

    initial begin
        n_tests = 0;
        n_fail  = 0;

        // Reset held for two cycles with in_valid asserted.
        reset         = 1'b0;
        bus.in_valid  = 1'b1;
        bus.in_data   = 32'hDEAD_BEEF;
        bus.out_ready = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk_state("reset", 3'd0, 1'b0, 32'd0, 1'b0, 16'd0);
        chk("reset.out_data", bus.out_data, 32'd0);
        reset        = 1'b1;
        bus.in_valid = 1'b0;

        //            vi    d      rdy   cnt   ov    od     full  drop
        vecs.push_back(mk(1'b0, 32'd0,  1'b0, 3'd0, 1'b0, 32'd0,  1'b0, 16'd0)); // idle
        vecs.push_back(mk(1'b0, 32'd0,  1'b1, 3'd0, 1'b0, 32'd0,  1'b0, 16'd0)); // ready while empty
        vecs.push_back(mk(1'b1, 32'd1,  1'b0, 3'd1, 1'b1, 32'd1,  1'b0, 16'd0)); // fill
        vecs.push_back(mk(1'b1, 32'd3,  1'b0, 3'd2, 1'b1, 32'd1,  1'b0, 16'd0));
        vecs.push_back(mk(1'b1, 32'd6,  1'b0, 3'd3, 1'b1, 32'd1,  1'b0, 16'd0));
        vecs.push_back(mk(1'b1, 32'd10, 1'b0, 3'd4, 1'b1, 32'd1,  1'b1, 16'd0));
        vecs.push_back(mk(1'b0, 32'd0,  1'b0, 3'd4, 1'b1, 32'd1,  1'b1, 16'd0)); // hold
        vecs.push_back(mk(1'b0, 32'd0,  1'b1, 3'd3, 1'b1, 32'd3,  1'b0, 16'd0)); // drain 1,3,6,10
        vecs.push_back(mk(1'b0, 32'd0,  1'b1, 3'd2, 1'b1, 32'd6,  1'b0, 16'd0));
        vecs.push_back(mk(1'b0, 32'd0,  1'b1, 3'd1, 1'b1, 32'd10, 1'b0, 16'd0));
        vecs.push_back(mk(1'b0, 32'd0,  1'b1, 3'd0, 1'b0, 32'd0,  1'b0, 16'd0));
        vecs.push_back(mk(1'b1, 32'd1,  1'b0, 3'd1, 1'b1, 32'd1,  1'b0, 16'd0)); // refill
        vecs.push_back(mk(1'b1, 32'd3,  1'b0, 3'd2, 1'b1, 32'd1,  1'b0, 16'd0));
        vecs.push_back(mk(1'b1, 32'd6,  1'b0, 3'd3, 1'b1, 32'd1,  1'b0, 16'd0));
        vecs.push_back(mk(1'b1, 32'd10, 1'b0, 3'd4, 1'b1, 32'd1,  1'b1, 16'd0));
        vecs.push_back(mk(1'b1, 32'd15, 1'b0, 3'd4, 1'b1, 32'd1,  1'b1, 16'd1)); // overflow
        vecs.push_back(mk(1'b1, 32'd21, 1'b0, 3'd4, 1'b1, 32'd1,  1'b1, 16'd2));
        vecs.push_back(mk(1'b1, 32'd99, 1'b1, 3'd4, 1'b1, 32'd3,  1'b1, 16'd2)); // full push+pop
        vecs.push_back(mk(1'b0, 32'd0,  1'b1, 3'd3, 1'b1, 32'd6,  1'b0, 16'd2)); // drain 3,6,10,99
        vecs.push_back(mk(1'b0, 32'd0,  1'b1, 3'd2, 1'b1, 32'd10, 1'b0, 16'd2));
        vecs.push_back(mk(1'b0, 32'd0,  1'b1, 3'd1, 1'b1, 32'd99, 1'b0, 16'd2));
        vecs.push_back(mk(1'b0, 32'd0,  1'b1, 3'd0, 1'b0, 32'd0,  1'b0, 16'd2));

        foreach (vecs[i]) begin
            step(vecs[i].vi, vecs[i].d, vecs[i].rdy);
            chk_state($sformatf("vec%0d", i), vecs[i].cnt, vecs[i].ov, vecs[i].od,
                      vecs[i].full, vecs[i].drop);
        end

        // Wrap-around: one entry primed, then nine simultaneous push/pop pairs.
        step(1'b1, 32'd0, 1'b0);
        chk_state("wrap0", 3'd1, 1'b1, 32'd0, 1'b0, 16'd2);
        for (int k = 1; k < 10; k++) begin
            step(1'b1, 32'(k), 1'b1);
            chk_state($sformatf("wrap%0d", k), 3'd1, 1'b1, 32'(k), 1'b0, 16'd2);
        end
        step(1'b0, 32'd0, 1'b1);
        chk_state("wrap_end", 3'd0, 1'b0, 32'd0, 1'b0, 16'd2);

        // Asynchronous reset between edges with three entries held.
        step(1'b1, 32'd5, 1'b0);
        step(1'b1, 32'd7, 1'b0);
        step(1'b1, 32'd8, 1'b0);
        chk_state("pre_areset", 3'd3, 1'b1, 32'd5, 1'b0, 16'd2);
        bus.in_valid = 1'b0;
        #3;
        reset = 1'b0;
        #1;
        chk_state("areset", 3'd0, 1'b0, 32'd0, 1'b0, 16'd0);
        chk("areset.out_data", bus.out_data, 32'd0);
        @(posedge clk);
        #1;
        reset = 1'b1;
        bus.in_valid  = 1'b1;
        bus.in_data   = 32'd42;
        bus.out_ready = 1'b0;
        #1;
        chk("no_bypass.out_valid", 32'(bus.out_valid), 32'd0);
        @(posedge clk);
        #1;
        chk_state("post_reset_push", 3'd1, 1'b1, 32'd42, 1'b0, 16'd0);
        bus.in_valid = 1'b0;

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
